// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, constants and divisor clamp for clk_div_n
package clk_div_pkg;

  // Run/park state of the divider
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } clk_div_state_e;

  // Smallest divisor that still yields a distinct high and low phase
  localparam int unsigned CLK_DIV_MIN = 2;

  // Divisors 0 and 1 cannot form a period; pull them up to the minimum
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    if (d < CLK_DIV_MIN) begin
      return CLK_DIV_MIN;
    end
    return d;
  endfunction

endpackage

// File: rtl/clk_div_negext.sv
// rtl/clk_div_negext.sv - optional negedge half-cycle extension and output OR (macro CLK_DIV_DUTY50_EN)
module clk_div_negext
  import clk_div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pos_q,
  input  logic odd,
  output logic clk_out
);

  logic neg_q;

`ifdef CLK_DIV_DUTY50_EN
  // Stretch the high phase by half a clk cycle for odd divisors
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q & odd;
    end
  end
`else
  // Purely posedge build: no extension stage exists
  logic unused_negext;
  assign unused_negext = &{1'b0, clk, rst_n, odd};
  assign neg_q = 1'b0;
`endif

  assign clk_out = pos_q | neg_q;

endmodule

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - programmable integer clock divider with run/park control and tick (macro CLK_DIV_DUTY50_EN)
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             div_err
);

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_RUN  = 1'(RUN);

  logic [0:0]       state;
  logic [WIDTH-1:0] cnt;
  logic             pos_q;

  // One extra bit so cnt+1 never wraps at the largest divisor
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH:0]   half_div;
  logic             period_end;
  logic             load;

  assign cnt_inc    = {1'b0, cnt} + 1'b1;
  assign half_div   = {2'b00, div_active[WIDTH-1:1]};
  assign period_end = (state == ST_RUN) && (cnt_inc == {1'b0, div_active});
  assign load       = en && ((state == ST_IDLE) || period_end);

  // Period counter, high-phase flop, tick and divisor register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pos_q      <= 1'b0;
      tick       <= 1'b0;
      div_active <= WIDTH'(RESET_DIV);
      div_err    <= 1'b0;
    end else if (load) begin
      state      <= ST_RUN;
      cnt        <= '0;
      pos_q      <= 1'b1;
      tick       <= 1'b1;
      div_active <= WIDTH'(clamp_div(32'(div)));
      div_err    <= (div < WIDTH'(CLK_DIV_MIN));
    end else if (period_end) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pos_q <= 1'b0;
      tick  <= 1'b0;
    end else if (state == ST_RUN) begin
      cnt   <= cnt_inc[WIDTH-1:0];
      pos_q <= (cnt_inc < half_div);
      tick  <= 1'b0;
    end
  end

  clk_div_negext u_negext (
    .clk     (clk),
    .rst_n   (rst_n),
    .pos_q   (pos_q),
    .odd     (div_active[0]),
    .clk_out (clk_out)
  );

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - directed self-checking bench for clk_div_n (macro CLK_DIV_DUTY50_EN)
module tb_clk_div_n;

`ifdef CLK_DIV_DUTY50_EN
  localparam bit DUTY50 = 1'b1;
`else
  localparam bit DUTY50 = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_active;
  logic       div_err;

  int n_cmp;
  int n_bad;

  clk_div_n #(
    .WIDTH     (8),
    .RESET_DIV (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div        (div),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_active (div_active),
    .div_err    (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walk one full output period of length d, checking both half cycles.
  // h2 is the expected high time in half-clk units.
  task automatic run_period(input string tag, input int d, input int chg_at,
                            input int new_div, input int drop_at);
    int h2;
    h2 = 2 * (d / 2) + ((DUTY50 && (d % 2 == 1)) ? 1 : 0);
    for (int k = 0; k < d; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_tick"}, int'(tick), int'(k == 0));
      chk({tag, "_hi"}, int'(clk_out), int'(2 * k < h2));
      chk({tag, "_div"}, int'(div_active), d);
      if (k == chg_at) div = 8'(new_div);
      if (k == drop_at) en = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, "_lo"}, int'(clk_out), int'(2 * k + 1 < h2));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    div   = 8'd4;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_div_active", int'(div_active), 5);
    chk("rst_div_err", int'(div_err), 0);

    @(negedge clk);
    rst_n = 1'b1;

    run_period("d4", 4, 0, 5, -1);
    run_period("d5", 5, 0, 4, -1);
    run_period("d4chg", 4, 1, 7, -1);
    run_period("d7", 7, 0, 6, -1);
    run_period("d6stop", 6, -1, 0, 0);

    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("idle_clk_out", int'(clk_out), 0);
      chk("idle_tick", int'(tick), 0);
      chk("idle_div_active", int'(div_active), 6);
    end
    en = 1'b1;

    run_period("d6re", 6, 2, 1, -1);
    run_period("d2clamp", 2, 0, 3, -1);
    chk("clamp_err", int'(div_err), 1);
    run_period("d3", 3, 0, 9, -1);
    chk("d3_err", int'(div_err), 0);

    @(posedge clk);
    #1;
    chk("d9_load_hi", int'(clk_out), 1);
    chk("d9_load_tick", int'(tick), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_div_active", int'(div_active), 5);
    @(negedge clk);
    #1;
    chk("arst_hold_clk_out", int'(clk_out), 0);
    rst_n = 1'b1;

    run_period("d9", 9, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_n.md
# clk_div_n

Programmable integer clock divider: the successor to the fixed divide-by-5 divider. It divides `clk` by a runtime divisor of 2..2^WIDTH-1 and gives a 50% duty cycle for both even and odd ratios. Divisor changes are glitch-free and take effect only at period boundaries. A run/park state machine also provides a one-cycle tick output, so the same block can drive either a derived clock or a clock-enable in the lab/SoC clocking tree.

## Interface
- `WIDTH`, 8, width of the divisor and internal counter
- `RESET_DIV`, 5, value `div_active` takes in reset (must be ≥2)

Ports:
- `clk`  in  1  source clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  run request, sampled on posedge at idle or period end
- `div`  in  WIDTH  requested divisor, sampled only at load points
- `clk_out`  out  1  divided clock
- `tick`  out  1  one-`clk`-cycle pulse in the first cycle of every output period
- `div_active`  out  WIDTH  divisor currently applied
- `div_err`  out  1  last loaded `div` was <2 and was clamped to 2

## Operation
- States are IDLE and RUN. Reset puts the block in IDLE.
- Reset values: `cnt`=0, `pos_q`=0, `neg_q`=0, `clk_out`=0, `tick`=0, `div_active`=RESET_DIV, `div_err`=0.
- Load point: any posedge in IDLE with `en`=1, or the posedge ending the last cycle of a period (`cnt`=D-1) with `en`=1. At a load point:
  - `div_active` <= max(`div`, 2), where `div` values 0 and 1 clamp to 2.
  - `div_err` <= (`div` < 2).
  - `cnt` <= 0, `pos_q` <= 1, `tick` <= 1.
  - The state becomes (or stays) RUN.
- In RUN when not at a load point:
  - `cnt` <= `cnt`+1.
  - `pos_q` <= (`cnt`+1 < H), where H = floor(D/2) and D = `div_active`.
  - `tick` <= 0.
- Period end with `en`=0: the state goes to IDLE with `cnt`=0, `pos_q`=0, `tick`=0. `div_active` and `div_err` hold their values.
- `en` is ignored mid-period. A stop always completes the current period, so there are no runt pulses.
- Mid-period `div` changes are ignored until the next load point.
- Odd extension: on negedge, `neg_q` <= `pos_q` & `div_active[0]`.
- `clk_out` = `pos_q` | `neg_q`. This gives a high time of D/2 `clk` periods for any D≥2.
- Counter arithmetic: `cnt+1` is compared in WIDTH+1 bits, so there is no wrap at D = 2^WIDTH-1.
- Asynchronous reset mid-period immediately forces all outputs to their reset values. Operation restarts from IDLE.

## Timing
- `clk_out` rises at the same posedge at which the load point registers. That is the first posedge with `en`=1 in IDLE, i.e. 1 cycle of latency from `en`.
- The period is exactly D `clk` cycles.
  - Even D: high for D/2 cycles.
  - Odd D: high for (D-1)/2 cycles plus a half cycle, falling on a negedge.
- `tick` is high for the first `clk` cycle of each period, coincident with the `clk_out` rising edge.
- A new divisor applies to the period that starts at the load edge. The old period always completes intact.
- After `en` drops, `clk_out` stays low starting from the end of the current period.

## Configuration
- `CLK_DIV_DUTY50_EN` defined: the negedge `neg_q` stage is present. Duty cycle is 50% for all D.
- `CLK_DIV_DUTY50_EN` undefined: no negedge logic; `neg_q` is tied to 0 and `clk_out`=`pos_q`. Odd D gives a high time of (D-1)/2 cycles. The design is purely posedge, which suits scan and STA-simple flows.

## Structure
- Shared package `clk_div_pkg` holds:
  - the state enum `clk_div_state_e` {IDLE, RUN}
  - the constant `CLK_DIV_MIN`=2
  - a `clamp_div` function
- Optional sub-module `clk_div_negext`: the macro-guarded negedge extension flop plus the output OR. It isolates the only negedge logic for CDC/STA review.

## Test plan
- Reset with `en`=1 held low → all outputs at reset values, `div_active`=5. Release with `div`=4 → `clk_out` 2 high / 2 low, period 4, `tick` every 4 cycles.
- `div`=5 with macro defined → high 2.5 cycles, period 5, falling edge on a negedge. Without the macro → high 2, low 3.
- `div` changed 4→7 at `cnt`=1 → current period stays 4 cycles, next period is 7 cycles, `div_active`=7 exactly at that load edge.
- `en` dropped at `cnt`=0 with D=6 → full 6-cycle period completes, then IDLE with `clk_out`=0. Re-assert `en` → `clk_out` high at the next posedge.
- `div`=1 loaded → `div_active`=2, `div_err`=1, period 2. Next load with `div`=3 → `div_err`=0.
- Assert `rst_n` low during the high phase at D=9 → `clk_out`, `tick` and `cnt` go to 0 immediately without waiting for a clock edge. Operation resumes from IDLE after release.
